// File: rtl/frame_align_ctrl.sv
// frame_align_ctrl: bitslip search and lock monitor for the ADC frame-clock word
module frame_align_ctrl #(
    parameter logic [7:0] FRAME_PATTERN = 8'hF0,
    parameter int SETTLE_CYCLES = 4,
    parameter int MATCH_COUNT = 16,
    parameter int MAX_SLIPS = 8,
    parameter int LOSS_COUNT = 4
) (
    input  logic       adc_clk,
    input  logic       adc_rst,
    input  logic       align_en,
    input  logic [7:0] frm_data,
    output logic       bitslip,
    output logic       aligned,
    output logic       align_err,
    output logic [3:0] slip_count,
    output logic [7:0] relock_count
);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] MATCH_LAST = 8'(MATCH_COUNT - 1);
    localparam logic [7:0] LOSS_LAST = 8'(LOSS_COUNT - 1);
    localparam logic [3:0] SLIP_MAX = 4'(MAX_SLIPS);

    typedef enum logic [2:0] {IDLE, SETTLE, CHECK, SLIP, LOCKED, FAIL} state_t;

    state_t state, state_d;
    logic [7:0] settle_cnt, settle_d, match_cnt, match_d, loss_cnt, loss_d, relock_d;
    logic [3:0] slip_d;
    logic match;

    assign match = frm_data == FRAME_PATTERN;

    always_comb begin
        state_d = state;
        settle_d = settle_cnt;
        match_d = match_cnt;
        loss_d = loss_cnt;
        slip_d = slip_count;
        relock_d = relock_count;
        if (!align_en) state_d = IDLE;
        else case (state)
            IDLE: begin
                state_d = SETTLE;
                settle_d = '0;
                match_d = '0;
                loss_d = '0;
                slip_d = '0;
            end
            SETTLE: begin
                settle_d = settle_cnt + 8'd1;
                if (settle_cnt == SETTLE_LAST) begin
                    state_d = CHECK;
                    match_d = '0;
                end
            end
            CHECK: begin
                if (match) begin
                    match_d = match_cnt + 8'd1;
                    if (match_cnt == MATCH_LAST) begin
                        state_d = LOCKED;
                        loss_d = '0;
                    end
                end else state_d = (slip_count < SLIP_MAX) ? SLIP : FAIL;
            end
            SLIP: begin
                state_d = SETTLE;
                settle_d = '0;
                slip_d = slip_count + 4'd1;
            end
            LOCKED: begin
                // a single good word forgives any earlier misses
                if (match) loss_d = '0;
                else if (loss_cnt == LOSS_LAST) begin
                    state_d = SETTLE;
                    settle_d = '0;
                    loss_d = '0;
                    slip_d = '0;
                    relock_d = relock_count + {7'd0, relock_count != 8'hFF};
                end else loss_d = loss_cnt + 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            state <= IDLE;
            settle_cnt <= '0;
            match_cnt <= '0;
            loss_cnt <= '0;
            slip_count <= '0;
            relock_count <= '0;
            bitslip <= 1'b0;
            aligned <= 1'b0;
            align_err <= 1'b0;
        end else begin
            state <= state_d;
            settle_cnt <= settle_d;
            match_cnt <= match_d;
            loss_cnt <= loss_d;
            slip_count <= slip_d;
            relock_count <= relock_d;
            bitslip <= state_d == SLIP;
            aligned <= state_d == LOCKED;
            align_err <= state_d == FAIL;
        end
    end
endmodule
